// File: rtl/pulse_pattern_gen.sv
// Periodic per-channel pulse source with phase offsets, emitted-edge counters and
// optional pairwise coincidence expectation (enable with PULSE_PATTERN_GEN_PAIR_EXPECT_EN).
module pulse_pattern_gen #(
  parameter int NCHAN = 4,
  parameter int NBITS = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start_i,
  input  logic             Abort_i,
  input  logic [NBITS-1:0] Period_i,
  input  logic [NBITS-1:0] Width_i,
  input  logic [NBITS-1:0] nPulses_i,
  input  logic [NCHAN-1:0] Mask_i,
  input  logic [NBITS-1:0] Delays_i [NCHAN],
  output logic [NCHAN-1:0] Channels,
  output logic             Busy_o,
  output logic             Done_o,
  output logic [NBITS-1:0] Cnt_emit [NCHAN],
  output logic [NBITS-1:0] Exp_pairs [NCHAN*(NCHAN-1)/2]
);

  localparam int NPAIR = NCHAN * (NCHAN - 1) / 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [NBITS-1:0] r_phase;
  logic [NBITS-1:0] r_per_cnt;
  logic [NBITS-1:0] r_period;
  logic [NBITS-1:0] r_width;
  logic [NBITS-1:0] r_npulse;
  logic [NCHAN-1:0] r_mask;
  logic [NBITS-1:0] r_delay [NCHAN];
  logic [NBITS-1:0] r_cnt [NCHAN];

  logic             w_start;
  logic [NCHAN-1:0] w_ch_next;
  logic [NCHAN-1:0] w_rise;
  logic [NBITS:0]   w_ph;
  logic [NBITS:0]   w_pm1;
  logic [NBITS:0]   w_w;

  assign w_start = (r_state == S_IDLE) && Start_i && !Abort_i;
  assign w_ph    = {1'b0, r_phase};
  assign w_pm1   = {1'b0, r_period} - 1'b1;
  assign w_w     = {1'b0, r_width};

  // Channel rule uses NBITS+1 bit arithmetic so d+W can never wrap.
  always_comb begin
    w_ch_next = '0;
    for (int unsigned i = 0; i < NCHAN; i++) begin
      if ((r_state == S_RUN) && !Abort_i && r_mask[i] &&
          (w_ph >= {1'b0, r_delay[i]}) &&
          ((w_ph - {1'b0, r_delay[i]}) < w_w) &&
          (w_ph != w_pm1))
        w_ch_next[i] = 1'b1;
    end
  end

  assign w_rise = w_ch_next & ~Channels;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state   <= S_IDLE;
      r_phase   <= '0;
      r_per_cnt <= '0;
      Channels  <= '0;
    end else begin
      Channels <= w_ch_next;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            if (nPulses_i != '0) begin
              r_state   <= S_RUN;
              r_period  <= (Period_i < NBITS'(2)) ? NBITS'(2) : Period_i;
              r_width   <= (Width_i == '0) ? NBITS'(1) : Width_i;
              r_npulse  <= nPulses_i;
              r_mask    <= Mask_i;
              r_delay   <= Delays_i;
              r_phase   <= '0;
              r_per_cnt <= '0;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_RUN: begin
          if (Abort_i) begin
            r_state <= S_IDLE;
          end else if (r_phase == r_period - 1'b1) begin
            r_phase <= '0;
            if (r_per_cnt == r_npulse - 1'b1)
              r_state <= S_DONE;
            else
              r_per_cnt <= r_per_cnt + 1'b1;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Counters are cleared by any accepted start, including the zero-repeat case.
  always_ff @(posedge Clk) begin
    if (Rst || w_start) begin
      for (int unsigned i = 0; i < NCHAN; i++)
        r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NCHAN; i++)
        if (w_rise[i] && (r_cnt[i] != '1))
          r_cnt[i] <= r_cnt[i] + 1'b1;
    end
  end

  assign Cnt_emit = r_cnt;
  assign Busy_o   = (r_state == S_RUN);
  assign Done_o   = (r_state == S_DONE);

`ifdef PULSE_PATTERN_GEN_PAIR_EXPECT_EN
  logic [NPAIR-1:0] w_pair_hit;
  logic [NBITS-1:0] r_pairs [NPAIR];

  // Pair index k = i*(2*NCHAN-i-1)/2 + (j-i-1) enumerates (i<j), i outer, j inner.
  for (genvar gi = 0; gi < NCHAN; gi++) begin : g_i
    for (genvar gj = gi + 1; gj < NCHAN; gj++) begin : g_j
      assign w_pair_hit[gi*(2*NCHAN-gi-1)/2 + gj - gi - 1] = w_rise[gi] & w_rise[gj];
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst || w_start) begin
      for (int unsigned k = 0; k < NPAIR; k++)
        r_pairs[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NPAIR; k++)
        if (w_pair_hit[k] && (r_pairs[k] != '1))
          r_pairs[k] <= r_pairs[k] + 1'b1;
    end
  end

  assign Exp_pairs = r_pairs;
`else
  always_comb begin
    for (int unsigned k = 0; k < NPAIR; k++)
      Exp_pairs[k] = '0;
  end
`endif

endmodule
